// File: rtl/conv_pkg.sv
// Shared constants and elaboration-time helpers for the conv adder tree.
package conv_pkg;

  // Ceiling log2 for elaboration-time sizing; clog2(0) = clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

  // Number of reduction levels; a single input still gets one register stage.
  function automatic int unsigned num_levels(input int unsigned n);
    return (n <= 1) ? 1 : clog2(n);
  endfunction

  // Elements entering level j: ceil(n / 2^j).
  function automatic int unsigned level_count(input int unsigned n, input int unsigned j);
    return (n + (32'd1 << j) - 32'd1) >> j;
  endfunction

  // Word width entering level j; each level grows by one bit.
  function automatic int unsigned level_width(input int unsigned dw, input int unsigned j);
    return dw + j;
  endfunction

  // Largest signed value representable in dw bits (dw <= 63).
  function automatic logic signed [63:0] sat_max(input int unsigned dw);
    return (64'sd1 <<< (dw - 1)) - 64'sd1;
  endfunction

  // Smallest signed value representable in dw bits (dw <= 63).
  function automatic logic signed [63:0] sat_min(input int unsigned dw);
    return -(64'sd1 <<< (dw - 1));
  endfunction

endpackage

// File: rtl/conv_add_tree_level.sv
// One reduction level: pairwise adds per channel into a registered stage.
// Odd element count passes the last word through sign-extended. When W_OUT is
// narrower than the full sum, the result is saturated (SAT_EN) or wrapped.
module conv_add_tree_level
  import conv_pkg::*;
#(
  parameter int unsigned KERNELS = 16,
  parameter int unsigned N_IN    = 8,
  parameter int unsigned W_IN    = 32,
  parameter int unsigned W_OUT   = W_IN + 1,
  parameter bit          SAT_EN  = 1'b0
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          en,
  input  logic [N_IN*KERNELS*W_IN-1:0]                  sum_in,
  output logic [((N_IN+1)/2)*KERNELS*W_OUT-1:0]         sum_out
);

  localparam int unsigned N_OUT = (N_IN + 1) / 2;
  localparam int unsigned WS    = W_IN + 1;
  localparam logic signed [WS-1:0] SAT_MAX = WS'(sat_max(W_OUT));
  localparam logic signed [WS-1:0] SAT_MIN = WS'(sat_min(W_OUT));

  logic [N_OUT*KERNELS*W_OUT-1:0] sum_d, sum_q;

  // Pairwise sums per channel, then reduce to the output word width.
  always_comb begin
    logic signed [W_IN-1:0]  a;
    logic signed [W_IN-1:0]  b;
    logic signed [WS-1:0]    s;
    logic signed [W_OUT-1:0] r;
    int                      b_idx;
    sum_d = '0;
    a     = '0;
    b     = '0;
    s     = '0;
    r     = '0;
    b_idx = 0;
    for (int o = 0; o < N_OUT; o++) begin
      for (int k = 0; k < KERNELS; k++) begin
        b_idx = (2*o + 1 < N_IN) ? 2*o + 1 : 2*o;
        a = sum_in[((2*o)*KERNELS + k)*W_IN +: W_IN];
        b = sum_in[(b_idx*KERNELS + k)*W_IN +: W_IN];
        if (b_idx == 2*o) b = '0;
        s = WS'(a) + WS'(b);
        if (SAT_EN && (W_OUT < WS) && (s > SAT_MAX))      r = W_OUT'(SAT_MAX);
        else if (SAT_EN && (W_OUT < WS) && (s < SAT_MIN)) r = W_OUT'(SAT_MIN);
        else                                              r = W_OUT'(s);
        sum_d[(o*KERNELS + k)*W_OUT +: W_OUT] = r;
      end
    end
  end

  // Stage register: reset wins over enable, en=0 holds.
  always_ff @(posedge clk) begin
    if (rst)     sum_q <= '0;
    else if (en) sum_q <= sum_d;
  end

  assign sum_out = sum_q;

endmodule

// File: rtl/conv_add_tree.sv
// Pipelined per-channel adder tree for the conv partial-sum path.
// Optional build macro CONV_ADD_SAT_EN: saturate the final sum to DW bits
// instead of two's-complement wrap. Latency is the same in both builds.
module conv_add_tree
  import conv_pkg::*;
#(
  parameter int unsigned KERNELS = 16,
  parameter int unsigned NUM_IN  = 8,
  parameter int unsigned DW      = 32,
  parameter int unsigned CNT_W   = 5,
  parameter int unsigned POS_W   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          in_valid,
  input  logic [0:NUM_IN*KERNELS*DW-1]  in_data,
  input  logic [CNT_W-1:0]              cnt_in,
  input  logic [POS_W-1:0]              pos_in,
  output logic                          out_valid,
  output logic [0:KERNELS*DW-1]         out_data,
  output logic [CNT_W-1:0]              cnt_out,
  output logic [POS_W-1:0]              pos_out
);

  localparam int unsigned L = num_levels(NUM_IN);

`ifdef CONV_ADD_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic [NUM_IN*KERNELS*DW-1:0] in_words;
  logic [KERNELS*DW-1:0]        sum_final;

  // Repack the MSB-first input bus into descending words, preserving word order.
  always_comb begin
    in_words = '0;
    for (int w = 0; w < NUM_IN*KERNELS; w++) begin
      in_words[w*DW +: DW] = in_data[w*DW +: DW];
    end
  end

  // Reduction levels; the last one narrows back to DW before its register.
  for (genvar j = 0; j < L; j++) begin : g_lvl
    localparam int unsigned N_J  = level_count(NUM_IN, j);
    localparam int unsigned W_J  = level_width(DW, j);
    localparam int unsigned WO_J = (j == L - 1) ? DW : W_J + 1;
    localparam int unsigned NO_J = (N_J + 1) / 2;

    logic [N_J*KERNELS*W_J-1:0]   lvl_in;
    logic [NO_J*KERNELS*WO_J-1:0] lvl_out;

    if (j == 0) begin : g_first
      assign lvl_in = in_words;
    end else begin : g_next
      assign lvl_in = g_lvl[j-1].lvl_out;
    end

    conv_add_tree_level #(
      .KERNELS (KERNELS),
      .N_IN    (N_J),
      .W_IN    (W_J),
      .W_OUT   (WO_J),
      .SAT_EN  (SAT_EN)
    ) u_level (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .sum_in  (lvl_in),
      .sum_out (lvl_out)
    );
  end

  assign sum_final = g_lvl[L-1].lvl_out;

  // Channel k of the final stage lands MSB-first at out_data[k*DW +: DW].
  always_comb begin
    out_data = '0;
    for (int k = 0; k < KERNELS; k++) begin
      out_data[k*DW +: DW] = sum_final[k*DW +: DW];
    end
  end

  logic [L-1:0]     vld_d, vld_q;
  logic [CNT_W-1:0] cnt_d [L];
  logic [CNT_W-1:0] cnt_q [L];
  logic [POS_W-1:0] pos_d [L];
  logic [POS_W-1:0] pos_q [L];

  // Valid and tag shift chain, advancing in lockstep with the data levels.
  always_comb begin
    vld_d = vld_q;
    cnt_d = cnt_q;
    pos_d = pos_q;
    if (en) begin
      vld_d[0] = in_valid;
      cnt_d[0] = cnt_in;
      pos_d[0] = pos_in;
      for (int i = 1; i < L; i++) begin
        vld_d[i] = vld_q[i-1];
        cnt_d[i] = cnt_q[i-1];
        pos_d[i] = pos_q[i-1];
      end
    end
  end

  // Chain registers; reset clears every slot regardless of en.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < L; i++) begin
        cnt_q[i] <= '0;
        pos_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
      pos_q <= pos_d;
    end
  end

  assign out_valid = vld_q[L-1];
  assign cnt_out   = cnt_q[L-1];
  assign pos_out   = pos_q[L-1];

endmodule

// File: tb/tb_conv_add_tree.sv
// Directed bench for conv_add_tree: an 8-input/16-channel instance and a
// 5-input/2-channel instance. Expectations follow CONV_ADD_SAT_EN if defined.
module tb_conv_add_tree;

  localparam int unsigned K  = 16;
  localparam int unsigned N  = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 5;
  localparam int unsigned PW = 4;
  localparam int unsigned K5 = 2;
  localparam int unsigned N5 = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst, en, iv;
  logic [0:N*K*DW-1]     din;
  logic [CW-1:0]         ci;
  logic [PW-1:0]         pi;
  logic                  ov;
  logic [0:K*DW-1]       dout;
  logic [CW-1:0]         co;
  logic [PW-1:0]         po;

  logic                  rst5, en5, iv5;
  logic [0:N5*K5*DW-1]   din5;
  logic [CW-1:0]         ci5;
  logic [PW-1:0]         pi5;
  logic                  ov5;
  logic [0:K5*DW-1]      dout5;
  logic [CW-1:0]         co5;
  logic [PW-1:0]         po5;

  int n_vec = 0;
  int n_mis = 0;

  conv_add_tree #(.KERNELS(K), .NUM_IN(N), .DW(DW), .CNT_W(CW), .POS_W(PW)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(iv), .in_data(din),
    .cnt_in(ci), .pos_in(pi), .out_valid(ov), .out_data(dout),
    .cnt_out(co), .pos_out(po)
  );

  conv_add_tree #(.KERNELS(K5), .NUM_IN(N5), .DW(DW), .CNT_W(CW), .POS_W(PW)) dut5 (
    .clk(clk), .rst(rst5), .en(en5), .in_valid(iv5), .in_data(din5),
    .cnt_in(ci5), .pos_in(pi5), .out_valid(ov5), .out_data(dout5),
    .cnt_out(co5), .pos_out(po5)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every word of channel k gets base + k.
  task automatic fill(input logic [31:0] base);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < K; k++)
        din[(i*K + k)*DW +: DW] = base + 32'(k);
  endtask

  task automatic fill_const(input logic [31:0] v);
    for (int i = 0; i < N*K; i++) din[i*DW +: DW] = v;
  endtask

  function automatic logic [31:0] ch(input int k);
    return dout[k*DW +: DW];
  endfunction

  initial begin
    logic [31:0] v5 [N5];
    int sent;
    int got;
    logic exp_v;

    rst = 1'b1; en = 1'b0; iv = 1'b0; din = '0; ci = '0; pi = '0;
    rst5 = 1'b1; en5 = 1'b0; iv5 = 1'b0; din5 = '0; ci5 = '0; pi5 = '0;
    step();
    step();
    chk("rst_valid", 32'(ov), 32'd0);
    chk("rst_data0", ch(0), 32'd0);
    chk("rst_data15", ch(15), 32'd0);
    chk("rst_cnt", 32'(co), 32'd0);
    chk("rst_pos", 32'(po), 32'd0);
    chk("rst5_valid", 32'(ov5), 32'd0);
    rst = 1'b0;
    rst5 = 1'b0;

    // Uniform inputs k+1 with tags 7/3.
    en = 1'b1;
    fill(32'd1); iv = 1'b1; ci = 5'd7; pi = 4'd3;
    step();
    iv = 1'b0;
    step();
    chk("t1_early_valid", 32'(ov), 32'd0);
    step();
    chk("t1_valid", 32'(ov), 32'd1);
    for (int k = 0; k < K; k++) chk($sformatf("t1_ch%0d", k), ch(k), 32'(8*(k+1)));
    chk("t1_cnt", 32'(co), 32'd7);
    chk("t1_pos", 32'(po), 32'd3);
    step();
    chk("t1_bubble", 32'(ov), 32'd0);

    // Odd input count with a negative pass-through element.
    v5[0] = 32'd1; v5[1] = 32'd2; v5[2] = 32'd3; v5[3] = 32'd4; v5[4] = -32'sd20;
    for (int i = 0; i < N5; i++) begin
      din5[(i*K5 + 0)*DW +: DW] = v5[i];
      din5[(i*K5 + 1)*DW +: DW] = 32'd7;
    end
    en5 = 1'b1; iv5 = 1'b1; ci5 = 5'd4; pi5 = 4'd9;
    step();
    iv5 = 1'b0;
    step();
    step();
    chk("t2_valid", 32'(ov5), 32'd1);
    chk("t2_ch0", dout5[0 +: DW], 32'hFFFF_FFF6);
    chk("t2_ch1", dout5[DW +: DW], 32'd35);
    chk("t2_cnt", 32'(co5), 32'd4);

    // Overflow at both extremes.
    fill_const(32'h7FFF_FFFF); iv = 1'b1;
    step();
    iv = 1'b0;
    step();
    step();
`ifdef CONV_ADD_SAT_EN
    chk("t4_pos_ch0", ch(0), 32'h7FFF_FFFF);
    chk("t4_pos_ch15", ch(15), 32'h7FFF_FFFF);
`else
    chk("t4_pos_ch0", ch(0), 32'hFFFF_FFF8);
    chk("t4_pos_ch15", ch(15), 32'hFFFF_FFF8);
`endif
    fill_const(32'h8000_0000); iv = 1'b1;
    step();
    iv = 1'b0;
    step();
    step();
`ifdef CONV_ADD_SAT_EN
    chk("t4_neg_ch0", ch(0), 32'h8000_0000);
    chk("t4_neg_ch9", ch(9), 32'h8000_0000);
`else
    chk("t4_neg_ch0", ch(0), 32'h0000_0000);
    chk("t4_neg_ch9", ch(9), 32'h0000_0000);
`endif

    // Ten-sample stream with a two-cycle stall.
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 40 && got < 10; cyc++) begin
      en = !(cyc == 5 || cyc == 6);
      if (sent < 10) begin
        iv = 1'b1; ci = CW'(sent); fill(32'(sent*100));
      end else begin
        iv = 1'b0;
      end
      step();
      if (en) begin
        if (sent < 10) sent++;
        if (ov) begin
          chk("t3_cnt", 32'(co), 32'(got));
          chk("t3_data", ch(3), 32'(8*(got*100 + 3)));
          got++;
        end
      end else begin
        chk("t3_hold_valid", 32'(ov), 32'd1);
        chk("t3_hold_cnt", 32'(co), 32'(got - 1));
        chk("t3_hold_data", ch(3), 32'(8*((got-1)*100 + 3)));
      end
    end
    en = 1'b1;
    chk("t3_count", 32'(got), 32'd10);
    step();
    chk("t3_no_dup", 32'(ov), 32'd0);

    // Reset with samples in flight.
    iv = 1'b1; pi = 4'd2;
    for (int s = 1; s <= 3; s++) begin
      ci = CW'(s); fill(32'(s*10));
      step();
    end
    chk("t5_pre_valid", 32'(ov), 32'd1);
    chk("t5_pre_cnt", 32'(co), 32'd1);
    chk("t5_pre_ch0", ch(0), 32'd80);
    rst = 1'b1; iv = 1'b0;
    step();
    chk("t5_rst_valid", 32'(ov), 32'd0);
    chk("t5_rst_ch0", ch(0), 32'd0);
    chk("t5_rst_ch15", ch(15), 32'd0);
    chk("t5_rst_cnt", 32'(co), 32'd0);
    chk("t5_rst_pos", 32'(po), 32'd0);
    rst = 1'b0;
    iv = 1'b1; ci = 5'd9; pi = 4'd5; fill(32'd50);
    step();
    iv = 1'b0;
    chk("t5_post1_valid", 32'(ov), 32'd0);
    step();
    chk("t5_post2_valid", 32'(ov), 32'd0);
    step();
    chk("t5_post3_valid", 32'(ov), 32'd1);
    chk("t5_post3_cnt", 32'(co), 32'd9);
    chk("t5_post3_pos", 32'(po), 32'd5);
    chk("t5_post3_ch2", ch(2), 32'd416);
    step();
    chk("t5_post4_valid", 32'(ov), 32'd0);

    // Alternating valid/bubble with signed data.
    for (int c = 0; c < 10; c++) begin
      iv = (c < 8) ? ((c % 2) == 0) : 1'b0;
      ci = CW'(c);
      fill(32'(3*c - 5));
      step();
      if (c >= 2) begin
        exp_v = ((c - 2) < 8) && (((c - 2) % 2) == 0);
        chk($sformatf("t6_valid_%0d", c), 32'(ov), 32'(exp_v));
        if (exp_v) begin
          chk($sformatf("t6_ch1_%0d", c), ch(1), 32'(8*(3*(c-2) - 4)));
          chk($sformatf("t6_cnt_%0d", c), 32'(co), 32'(c - 2));
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
